// File: rtl/tcp_tx_open_flow_ctrl.sv
// Active-open TCP connection controller: allocates a flow, sends SYN, waits for
// SYN-ACK with timed retransmission, completes the handshake and reports the result.
module tcp_tx_open_flow_ctrl #(
    parameter int FLOWID_W           = 4,
    parameter int TUPLE_W            = 96,
    parameter int SYN_TIMEOUT_CYCLES = 1000000,
    parameter int MAX_SYN_RETRIES    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                app_open_req_val,
    output logic                app_open_req_rdy,
    input  logic [TUPLE_W-1:0]  app_open_tuple,
    input  logic                flowid_avail,
    input  logic [FLOWID_W-1:0] flowid_alloc_id,
    output logic                flowid_manager_req,
    output logic                flowid_free_val,
    input  logic                flowid_free_rdy,
    output logic                init_state_val,
    input  logic                init_state_rdy,
    output logic                tx_pkt_val,
    input  logic                tx_pkt_rdy,
    output logic [7:0]          tx_pkt_flags,
    input  logic                rx_ctrl_val,
    output logic                rx_ctrl_rdy,
    input  logic [FLOWID_W-1:0] rx_ctrl_flowid,
    input  logic [7:0]          rx_ctrl_flags,
    output logic                app_open_resp_val,
    input  logic                app_open_resp_rdy,
    output logic                app_open_resp_ok,
    output logic [FLOWID_W-1:0] cur_flowid,
    output logic [TUPLE_W-1:0]  cur_tuple,
    output logic                busy
);

    // Widths are floored at 1 so degenerate parameter values still elaborate.
    localparam int TMR_W = (SYN_TIMEOUT_CYCLES > 1) ? $clog2(SYN_TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_SYN_RETRIES > 0) ? $clog2(MAX_SYN_RETRIES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SYN_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_SYN_RETRIES);

    localparam logic [7:0] FLG_SYN    = 8'h02;
    localparam logic [7:0] FLG_ACK    = 8'h10;
    localparam logic [7:0] FLG_SYNACK = 8'h12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_INIT,
        S_SEND_SYN,
        S_WAIT,
        S_SEND_ACK,
        S_FREE,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [FLOWID_W-1:0] r_flowid;
    logic [TUPLE_W-1:0]  r_tuple;
    logic                r_resp_ok;
    logic [TMR_W-1:0]    r_timer;
    logic [RTY_W-1:0]    r_retry;

    logic w_rx_hit;
    logic w_synack;
    logic w_rst;
    logic w_expired;

    // Packets for other flows or with uninteresting flags are consumed and ignored.
    assign w_rx_hit  = rx_ctrl_val && (rx_ctrl_flowid == r_flowid);
    assign w_synack  = w_rx_hit && (rx_ctrl_flags == FLG_SYNACK);
    assign w_rst     = w_rx_hit && rx_ctrl_flags[2];
    assign w_expired = (r_timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_flowid  <= '0;
            r_tuple   <= '0;
            r_resp_ok <= 1'b0;
            r_timer   <= '0;
            r_retry   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (app_open_req_val) begin
                        r_tuple   <= app_open_tuple;
                        r_resp_ok <= 1'b0;
                        r_state   <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (flowid_avail) begin
                        r_flowid <= flowid_alloc_id;
                        r_state  <= S_INIT;
                    end else begin
                        r_resp_ok <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end
                S_INIT: begin
                    if (init_state_rdy) begin
                        r_retry <= '0;
                        r_state <= S_SEND_SYN;
                    end
                end
                S_SEND_SYN: begin
                    if (tx_pkt_rdy) begin
                        r_timer <= TMR_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A SYN-ACK in the expiry cycle still completes the handshake.
                    if (w_synack) begin
                        r_state <= S_SEND_ACK;
                    end else if (w_rst) begin
                        r_state <= S_FREE;
                    end else if (w_expired) begin
                        if (r_retry == RTY_MAX) begin
                            r_state <= S_FREE;
                        end else begin
                            r_retry <= r_retry + RTY_W'(1);
                            r_state <= S_SEND_SYN;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_SEND_ACK: begin
                    if (tx_pkt_rdy) begin
                        r_resp_ok <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_FREE: begin
                    if (flowid_free_rdy) begin
                        r_resp_ok <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (app_open_resp_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign app_open_req_rdy   = (r_state == S_IDLE);
    assign busy               = (r_state != S_IDLE);
    assign flowid_manager_req = (r_state == S_ALLOC) && flowid_avail;
    assign init_state_val     = (r_state == S_INIT);
    assign tx_pkt_val         = (r_state == S_SEND_SYN) || (r_state == S_SEND_ACK);
    assign tx_pkt_flags       = (r_state == S_SEND_SYN) ? FLG_SYN :
                                (r_state == S_SEND_ACK) ? FLG_ACK : 8'h00;
    assign rx_ctrl_rdy        = (r_state == S_WAIT);
    assign flowid_free_val    = (r_state == S_FREE);
    assign app_open_resp_val  = (r_state == S_RESP);
    assign app_open_resp_ok   = r_resp_ok;
    assign cur_flowid         = r_flowid;
    assign cur_tuple          = r_tuple;

endmodule

// File: tb/tb_tcp_tx_open_flow_ctrl.sv
// Scoreboard bench for tcp_tx_open_flow_ctrl: a transaction-level model predicts
// every handshake event and WAIT duration; a monitor compares as the DUT emits them.
module tb_tcp_tx_open_flow_ctrl;

    localparam int FW = 4;
    localparam int TW = 96;
    localparam int T  = 16;
    localparam int R  = 2;

    localparam logic [1:0] K_INIT = 2'd0;
    localparam logic [1:0] K_TX   = 2'd1;
    localparam logic [1:0] K_FREE = 2'd2;
    localparam logic [1:0] K_RESP = 2'd3;

    logic          clk;
    logic          rst_n;
    logic          app_open_req_val;
    logic          app_open_req_rdy;
    logic [TW-1:0] app_open_tuple;
    logic          flowid_avail;
    logic [FW-1:0] flowid_alloc_id;
    logic          flowid_manager_req;
    logic          flowid_free_val;
    logic          flowid_free_rdy;
    logic          init_state_val;
    logic          init_state_rdy;
    logic          tx_pkt_val;
    logic          tx_pkt_rdy;
    logic [7:0]    tx_pkt_flags;
    logic          rx_ctrl_val;
    logic          rx_ctrl_rdy;
    logic [FW-1:0] rx_ctrl_flowid;
    logic [7:0]    rx_ctrl_flags;
    logic          app_open_resp_val;
    logic          app_open_resp_rdy;
    logic          app_open_resp_ok;
    logic [FW-1:0] cur_flowid;
    logic [TW-1:0] cur_tuple;
    logic          busy;

    tcp_tx_open_flow_ctrl #(
        .FLOWID_W(FW), .TUPLE_W(TW), .SYN_TIMEOUT_CYCLES(T), .MAX_SYN_RETRIES(R)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .app_open_req_val(app_open_req_val), .app_open_req_rdy(app_open_req_rdy),
        .app_open_tuple(app_open_tuple),
        .flowid_avail(flowid_avail), .flowid_alloc_id(flowid_alloc_id),
        .flowid_manager_req(flowid_manager_req),
        .flowid_free_val(flowid_free_val), .flowid_free_rdy(flowid_free_rdy),
        .init_state_val(init_state_val), .init_state_rdy(init_state_rdy),
        .tx_pkt_val(tx_pkt_val), .tx_pkt_rdy(tx_pkt_rdy), .tx_pkt_flags(tx_pkt_flags),
        .rx_ctrl_val(rx_ctrl_val), .rx_ctrl_rdy(rx_ctrl_rdy),
        .rx_ctrl_flowid(rx_ctrl_flowid), .rx_ctrl_flags(rx_ctrl_flags),
        .app_open_resp_val(app_open_resp_val), .app_open_resp_rdy(app_open_resp_rdy),
        .app_open_resp_ok(app_open_resp_ok),
        .cur_flowid(cur_flowid), .cur_tuple(cur_tuple), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]    kind;
        logic [7:0]    flg;
        logic [FW-1:0] fid;
        logic [TW-1:0] tup;
        logic          ok;
        logic          alloc;
    } exp_t;

    typedef struct packed {
        logic [FW-1:0] fid;
        logic [7:0]    flg;
        logic [7:0]    gap;
    } pkt_t;

    exp_t exp_q[$];
    int   wait_q[$];
    int   rxn_q[$];
    pkt_t rxp_q[$];
    int   att_n[$];
    pkt_t att_p[$];

    int            checks = 0;
    int            errors = 0;
    int            resp_cnt = 0;
    int            cyc = 0;
    bit            sb_en = 1'b1;
    bit            rand_rdy = 1'b0;
    bit            tx_hold = 1'b0;
    logic [FW-1:0] last_id = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input logic [1:0] k, input logic [7:0] f, input logic [FW-1:0] id,
                                     input logic [TW-1:0] tp, input logic ok, input logic al);
        exp_t e;
        e.kind = k; e.flg = f; e.fid = id; e.tup = tp; e.ok = ok; e.alloc = al;
        exp_q.push_back(e);
    endfunction

    function automatic void add_pkt(input logic [FW-1:0] f, input logic [7:0] fl, input int g);
        pkt_t p;
        p.fid = f; p.flg = fl; p.gap = 8'(g);
        att_p.push_back(p);
    endfunction

    // Ready generator: random backpressure or all-ready, with an optional TX stall.
    initial begin
        init_state_rdy = 1'b1; tx_pkt_rdy = 1'b1; flowid_free_rdy = 1'b1; app_open_resp_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) begin
                init_state_rdy    = ($urandom % 4) != 0;
                tx_pkt_rdy        = ($urandom % 4) != 0;
                flowid_free_rdy   = ($urandom % 4) != 0;
                app_open_resp_rdy = ($urandom % 4) != 0;
            end else begin
                init_state_rdy = 1'b1; flowid_free_rdy = 1'b1; app_open_resp_rdy = 1'b1;
                tx_pkt_rdy = !tx_hold;
            end
        end
    end

    // RX driver: after each accepted SYN, replays that attempt's packet plan.
    initial begin
        int   n;
        pkt_t p;
        rx_ctrl_val = 1'b0; rx_ctrl_flowid = '0; rx_ctrl_flags = '0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_pkt_val && tx_pkt_rdy && tx_pkt_flags == 8'h02 && rxn_q.size() > 0) begin
                n = rxn_q.pop_front();
                @(posedge clk); #1;
                for (int i = 0; i < n; i++) begin
                    p = rxp_q.pop_front();
                    for (int k = 0; k < int'(p.gap); k++) begin
                        @(posedge clk); #1;
                    end
                    rx_ctrl_val = 1'b1; rx_ctrl_flowid = p.fid; rx_ctrl_flags = p.flg;
                    @(negedge clk);
                    chk(rx_ctrl_rdy === 1'b1, "rx_rdy_in_wait", rx_ctrl_rdy, 1);
                    @(posedge clk); #1;
                    rx_ctrl_val = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and on each completed WAIT period.
    initial begin
        int   run;
        int   pulses;
        int   w;
        exp_t e;
        run = 0; pulses = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0; pulses = 0;
                continue;
            end
            chk(tx_pkt_val || tx_pkt_flags == 8'h00, "flags_idle_zero", tx_pkt_flags, 0);
            if (flowid_manager_req) pulses++;
            if (!sb_en) begin
                run = 0;
                continue;
            end
            if (rx_ctrl_rdy) run++;
            else if (run > 0) begin
                if (wait_q.size() == 0) chk(0, "wait_unexpected", run, 0);
                else begin
                    w = wait_q.pop_front();
                    chk(run == w, "wait_cycles", run, w);
                end
                run = 0;
            end
            if ((init_state_val && init_state_rdy) || (tx_pkt_val && tx_pkt_rdy) ||
                (flowid_free_val && flowid_free_rdy) || (app_open_resp_val && app_open_resp_rdy)) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_event", {init_state_val, tx_pkt_val, flowid_free_val, app_open_resp_val}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (init_state_val) begin
                        chk(e.kind == K_INIT, "kind_init", K_INIT, e.kind);
                        if (e.kind == K_INIT) begin
                            chk(cur_flowid == e.fid, "init_flowid", cur_flowid, e.fid);
                            chk(cur_tuple == e.tup, "init_tuple", cur_tuple, e.tup);
                        end
                    end else if (tx_pkt_val) begin
                        chk(e.kind == K_TX, "kind_tx", K_TX, e.kind);
                        if (e.kind == K_TX) begin
                            chk(tx_pkt_flags == e.flg, "tx_flags", tx_pkt_flags, e.flg);
                            chk(cur_flowid == e.fid, "tx_flowid", cur_flowid, e.fid);
                            chk(cur_tuple == e.tup, "tx_tuple", cur_tuple, e.tup);
                        end
                    end else if (flowid_free_val) begin
                        chk(e.kind == K_FREE, "kind_free", K_FREE, e.kind);
                        if (e.kind == K_FREE) chk(cur_flowid == e.fid, "free_flowid", cur_flowid, e.fid);
                    end else begin
                        chk(e.kind == K_RESP, "kind_resp", K_RESP, e.kind);
                        if (e.kind == K_RESP) begin
                            chk(app_open_resp_ok == e.ok, "resp_ok", app_open_resp_ok, e.ok);
                            chk(cur_flowid == e.fid, "resp_flowid", cur_flowid, e.fid);
                            chk(pulses == int'(e.alloc), "mgr_req_pulses", pulses, e.alloc);
                        end
                        pulses = 0;
                        resp_cnt++;
                    end
                end
            end
        end
    end

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic check_reset(input string tag);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(app_open_req_rdy == 1'b1, {tag, "_req_rdy"}, app_open_req_rdy, 1);
        chk(rx_ctrl_rdy == 1'b0, {tag, "_rx_rdy"}, rx_ctrl_rdy, 0);
        chk(tx_pkt_val == 1'b0 && tx_pkt_flags == 8'h00, {tag, "_tx"}, {tx_pkt_val, tx_pkt_flags}, 0);
        chk(init_state_val == 1'b0 && flowid_free_val == 1'b0 && app_open_resp_val == 1'b0,
            {tag, "_vals"}, {init_state_val, flowid_free_val, app_open_resp_val}, 0);
        chk(flowid_manager_req == 1'b0, {tag, "_mgr_req"}, flowid_manager_req, 0);
        chk(app_open_resp_ok == 1'b0, {tag, "_resp_ok"}, app_open_resp_ok, 0);
        chk(cur_flowid == '0 && cur_tuple == '0, {tag, "_cur_regs"}, {cur_flowid, cur_tuple}, 0);
    endtask

    // Predicts the whole connection attempt from the plan, then drives the request.
    task automatic run_txn(input bit avail, input logic [FW-1:0] id, input int exp_lat);
        logic [TW-1:0] tup;
        int            idx, n, arr, outcome, acc, lat, target;
        bit            seen, done;
        pkt_t          p;
        tup = {$urandom, $urandom, $urandom};
        if (!avail) begin
            push_exp(K_RESP, 8'h00, last_id, tup, 1'b0, 1'b0);
        end else begin
            last_id = id;
            push_exp(K_INIT, 8'h00, id, tup, 1'b0, 1'b0);
            idx = 0;
            for (int a = 0; a <= R; a++) begin
                push_exp(K_TX, 8'h02, id, tup, 1'b0, 1'b0);
                n = (a < att_n.size()) ? att_n[a] : 0;
                rxn_q.push_back(n);
                outcome = 0; arr = 0;
                for (int i = 0; i < n; i++) begin
                    p = att_p[idx]; idx++;
                    rxp_q.push_back(p);
                    arr += int'(p.gap) + 1;
                    if (outcome == 0 && p.fid == id && p.flg == 8'h12) outcome = 1;
                    else if (outcome == 0 && p.fid == id && p.flg[2]) outcome = 2;
                end
                wait_q.push_back(outcome != 0 ? arr : T);
                if (outcome == 1) begin
                    push_exp(K_TX, 8'h10, id, tup, 1'b0, 1'b0);
                    push_exp(K_RESP, 8'h00, id, tup, 1'b1, 1'b1);
                    break;
                end
                if (outcome == 2 || a == R) begin
                    push_exp(K_FREE, 8'h00, id, tup, 1'b0, 1'b0);
                    push_exp(K_RESP, 8'h00, id, tup, 1'b0, 1'b1);
                    break;
                end
            end
        end
        att_n.delete();
        att_p.delete();

        target = resp_cnt + 1;
        flowid_avail = avail;
        flowid_alloc_id = avail ? id : FW'($urandom);
        app_open_tuple = tup;
        app_open_req_val = 1'b1;
        done = 1'b0;
        acc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (app_open_req_rdy) begin
                done = 1'b1; acc = cyc;
                break;
            end
        end
        if (!done) begin
            chk(0, "req_accept_timeout", 0, 1);
            finish_now();
        end
        @(posedge clk); #1;
        app_open_req_val = 1'b0;
        app_open_tuple = {$urandom, $urandom, $urandom};
        seen = 1'b0; done = 1'b0; lat = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (app_open_resp_val && !seen) begin
                seen = 1'b1; lat = cyc - acc;
            end
            if (resp_cnt >= target) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk(0, "resp_timeout", resp_cnt, target);
            finish_now();
        end
        if (exp_lat >= 0) chk(lat == exp_lat, "resp_latency", lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic gen_random_plan(input logic [FW-1:0] id);
        int dec, nj, cnt;
        logic [7:0] junk_flags [6];
        logic [7:0] rst_flags [4];
        junk_flags = '{8'h10, 8'h11, 8'h18, 8'h02, 8'h00, 8'h13};
        rst_flags  = '{8'h04, 8'h14, 8'h16, 8'h24};
        for (int a = 0; a <= R; a++) begin
            dec = $urandom % 4;
            if ((dec == 1 || dec == 2) && ($urandom % 5) == 0) begin
                add_pkt(id, (dec == 1) ? 8'h12 : rst_flags[$urandom % 4], T - 1);
                att_n.push_back(1);
                continue;
            end
            nj = $urandom % 3;
            cnt = 0;
            for (int j = 0; j < nj; j++) begin
                if ($urandom % 2) add_pkt(id + FW'(1 + ($urandom % 15)), 8'h12, $urandom % 4);
                else add_pkt(id, junk_flags[$urandom % 6], $urandom % 4);
                cnt++;
            end
            if (dec == 1) begin add_pkt(id, 8'h12, $urandom % 4); cnt++; end
            if (dec == 2) begin add_pkt(id, rst_flags[$urandom % 4], $urandom % 4); cnt++; end
            att_n.push_back(cnt);
        end
    endtask

    initial begin
        int run;
        bit found;
        rst_n = 1'b0;
        app_open_req_val = 1'b0;
        app_open_tuple = '0;
        flowid_avail = 1'b0;
        flowid_alloc_id = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Happy path: SYN-ACK in the third WAIT cycle.
        add_pkt(4'd5, 8'h12, 2); att_n.push_back(1);
        run_txn(1'b1, 4'd5, -1);
        // Minimum latency: SYN-ACK in the first WAIT cycle.
        add_pkt(4'd5, 8'h12, 0); att_n.push_back(1);
        run_txn(1'b1, 4'd5, 6);
        // No flow ID available.
        run_txn(1'b0, 4'd0, 2);
        // Timeout exhaustion.
        run_txn(1'b1, 4'd7, -1);
        // Retry then success.
        att_n.push_back(0);
        add_pkt(4'd3, 8'h12, 3); att_n.push_back(1);
        run_txn(1'b1, 4'd3, -1);
        // Filtering then RST.
        add_pkt(4'd3, 8'h12, 0); add_pkt(4'd5, 8'h10, 0); add_pkt(4'd5, 8'h14, 0);
        att_n.push_back(3);
        run_txn(1'b1, 4'd5, -1);

        // Backpressure on SYN, full timeout afterwards, then reset mid-WAIT.
        sb_en = 1'b0;
        tx_hold = 1'b1;
        flowid_avail = 1'b1;
        flowid_alloc_id = 4'd9;
        app_open_tuple = {$urandom, $urandom, $urandom};
        app_open_req_val = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        app_open_req_val = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_pkt_val) begin found = 1'b1; break; end
        end
        chk(found, "bp_syn_seen", found, 1);
        for (int k = 0; k < 10; k++) begin
            chk(tx_pkt_val && tx_pkt_flags == 8'h02 && !rx_ctrl_rdy, "bp_hold",
                {tx_pkt_val, tx_pkt_flags, rx_ctrl_rdy}, {1'b1, 8'h02, 1'b0});
            @(negedge clk);
        end
        tx_hold = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rx_ctrl_rdy) begin found = 1'b1; break; end
        end
        run = 0;
        for (int k = 0; k < 100 && found; k++) begin
            if (!rx_ctrl_rdy) break;
            run++;
            @(negedge clk);
        end
        chk(run == T, "bp_wait_after_stall", run, T);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rx_ctrl_rdy) begin found = 1'b1; break; end
        end
        chk(found, "bp_second_wait", found, 1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset("async_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_id = '0;
        sb_en = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [FW-1:0] id;
            bit            av;
            id = FW'($urandom);
            av = ($urandom % 5) != 0;
            if (av) gen_random_plan(id);
            run_txn(av, id, -1);
        end
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        chk(wait_q.size() == 0 && rxn_q.size() == 0, "plans_drained", {wait_q.size(), rxn_q.size()}, 0);
        finish_now();
    end

endmodule
